pid_scheduler: RTL
==================

# pid_scheduler

Sequences one shared serial shift-add multiplier across the proportional, integral and derivative terms of the PID controller, so one multiply resource serves all three gains. On each accepted error sample it updates the integral and derivative operands, multiplies each by its 6-bit gain in turn, then sums, scales and saturates the three products into the controller output. It sits between the error-sample source and the actuator output register.

## Interface
- W, 6, signed width of error `e` and output `u`
- GW, 6, unsigned gain width; also the number of multiply cycles per term
- ACC_W, 12, signed width of the integral register
- SHIFT, 2, arithmetic right shift applied to the product sum before saturation
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  global enable; low freezes all state
- sample_valid  in  1  `e` is valid
- sample_ready  out  1  block can accept a sample; high only in IDLE with `ena`=1
- e  in  W  signed error sample
- K_p, K_i, K_d  in  GW  unsigned gains, sampled only at accept
- int_clr  in  1  synchronous clear of integral and previous-error registers
- u  out  W  signed controller output, held between updates
- u_valid  out  1  one-cycle pulse when `u` updates
- busy  out  1  high in every state except IDLE

## Operation
- Reset: `u`=0, `u_valid`=0, `busy`=0, integral=0, e_prior=0, state=IDLE. Reset mid-computation aborts the computation; no `u_valid` is issued.
- Accept: `sample_valid` && `sample_ready` at an edge. This latches `e` and all three gains, then enters LOAD.
- Gain changes after accept do not affect the sample in progress.
- FSM: IDLE -> LOAD -> MUL_P -> MUL_I -> MUL_D -> SUM -> IDLE.
- LOAD (1 cycle):
  - Integral update: integral <= sat_ACC_W(integral + e).
  - Derivative operand: d = e - e_prior, computed at W+1 bits.
  - e_prior <= e.
- MUL_x (GW cycles each):
  - Processes one gain bit per cycle, LSB first: prod += bit ? (operand << k) : 0.
  - Operands: P uses e, I uses the updated integral, D uses d.
  - Products are kept at full precision.
- SUM (1 cycle):
  - s = (prod_p + prod_i + prod_d) >>> SHIFT, computed at full internal width with no internal overflow.
  - u <= sat_W(s); `u_valid` pulses.
- Saturation clamps to [-2^(N-1), 2^(N-1)-1].
- `int_clr`:
  - Takes effect only in IDLE.
  - If it coincides with an accept, the clear applies first and LOAD then computes integral = 0 + e with e_prior = 0.
  - It is ignored while `busy`.
- `ena`=0: FSM, bit counter and all registers hold; `sample_ready`=0; a pending `u_valid` is deferred, not dropped.

## Timing
- Accept at edge T0 gives LOAD at T1, MUL_P at edges T2..T(GW+1), MUL_I through T(2GW+1), MUL_D through T(3GW+1), and SUM at T(3GW+2).
- `u` and `u_valid` update at T0+3·GW+2, which is T0+20 at defaults.
- `sample_ready` is combinational from state==IDLE and `ena`.
- Earliest next accept is at T0+3·GW+3, giving a throughput of 1 sample per 21 cycles.
- Each cycle of `ena`=0 during a computation adds exactly one cycle of latency.

## Configuration
- `PID_ANTI_WINDUP_EN` defined (conditional integration):
  - The LOAD integral update is skipped when the last output `u` was saturated and sign(e) matches the saturation direction (u=+max with e>0, or u=-min with e<0).
  - e_prior still updates.
- `PID_ANTI_WINDUP_EN` undefined: the integral always updates, limited only by ACC_W saturation.

## Test plan
- Reset check: assert `rst` mid-MUL_I, then release.
  - Required: `u`=0, `u_valid` never pulses, `busy`=0, `sample_ready`=1 on the next cycle.
- Proportional term: K_p=4, K_i=0, K_d=0, e=5.
  - Required: `u`=5 (20>>>2), `u_valid` at T0+20, next accept no earlier than T0+21.
- Derivative term: K_d=8, others 0, e=3 then e=3.
  - Required: first `u`=6, second `u`=0.
- Integral and saturation: K_i=63, e=31 repeated.
  - Required: `u`=31 (saturated) on the first sample.
  - Without `PID_ANTI_WINDUP_EN`: the integral saturates at 2047.
  - With `PID_ANTI_WINDUP_EN`: the integral stays 31 after the first sample.
- Negative saturation: K_p=63, e=-32.
  - Required: `u`=-32.
- Enable stall: drop `ena` for 5 cycles during MUL_P with the K_p=4, e=5 setup.
  - Required: `u`=5 at T0+25, exactly one `u_valid` pulse.

Source files
------------

// File: rtl/pid_scheduler.sv
// pid_scheduler: PID controller that time-shares one serial shift-add multiplier
// across the P, I and D terms. Optional conditional integration: PID_ANTI_WINDUP_EN.
module pid_scheduler #(
    parameter int W     = 6,
    parameter int GW    = 6,
    parameter int ACC_W = 12,
    parameter int SHIFT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic signed [W-1:0] e,
    input  logic [GW-1:0]       K_p,
    input  logic [GW-1:0]       K_i,
    input  logic [GW-1:0]       K_d,
    input  logic                int_clr,
    output logic signed [W-1:0] u,
    output logic                u_valid,
    output logic                busy
);
    // Sum width holds the largest product plus carry room for three terms.
    localparam int SW = ACC_W + GW + 2;
    localparam int CW = (GW > 1) ? $clog2(GW) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(GW - 1);
    localparam logic signed [W-1:0] U_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] U_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MUL_P = 3'd2,
        ST_MUL_I = 3'd3,
        ST_MUL_D = 3'd4,
        ST_SUM   = 3'd5
    } state_t;

    state_t                    state_r, state_nxt_s;
    logic [CW-1:0]             bit_cnt_r;
    logic signed [W-1:0]       e_r, e_prior_r;
    logic [GW-1:0]             kp_r, ki_r, kd_r;
    logic signed [W:0]         d_r, d_s;
    logic signed [ACC_W-1:0]   integ_r;
    logic signed [ACC_W:0]     integ_sum_s;
    logic signed [SW-1:0]      sum_r, op_s, addend_s, shifted_s;
    logic [GW-1:0]             gain_s;
    logic                      last_bit_s, hold_int_s;

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] x);
        if (x[ACC_W] == x[ACC_W-1]) sat_acc = x[ACC_W-1:0];
        else if (x[ACC_W])          sat_acc = {1'b1, {(ACC_W-1){1'b0}}};
        else                        sat_acc = {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] x);
        logic [SW-W:0] top;
        top = x[SW-1:W-1];
        if ((top == '0) || (top == '1)) sat_w = x[W-1:0];
        else if (x[SW-1])               sat_w = U_MIN;
        else                            sat_w = U_MAX;
    endfunction

    assign sample_ready = ena && (state_r == ST_IDLE);
    assign last_bit_s   = (bit_cnt_r == LAST_BIT);
    assign integ_sum_s  = {integ_r[ACC_W-1], integ_r} + {{(ACC_W+1-W){e_r[W-1]}}, e_r};
    assign d_s          = {e_r[W-1], e_r} - {e_prior_r[W-1], e_prior_r};
    assign shifted_s    = sum_r >>> SHIFT;

`ifdef PID_ANTI_WINDUP_EN
    // Hold the integral while the output sits on a rail and the error pushes further into it
    always_comb begin
        if ((u == U_MAX) && !e_r[W-1] && (e_r != '0)) hold_int_s = 1'b1;
        else if ((u == U_MIN) && e_r[W-1])             hold_int_s = 1'b1;
        else                                           hold_int_s = 1'b0;
    end
`else
    assign hold_int_s = 1'b0;
`endif

    // Next-state logic for the term sequencer
    always_comb begin
        state_nxt_s = state_r;
        if (!ena) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = sample_valid ? ST_LOAD : ST_IDLE;
                ST_LOAD:  state_nxt_s = ST_MUL_P;
                ST_MUL_P: state_nxt_s = last_bit_s ? ST_MUL_I : ST_MUL_P;
                ST_MUL_I: state_nxt_s = last_bit_s ? ST_MUL_D : ST_MUL_I;
                ST_MUL_D: state_nxt_s = last_bit_s ? ST_SUM : ST_MUL_D;
                ST_SUM:   state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Shared multiplier operand/gain selection and partial-product generation
    always_comb begin
        op_s     = '0;
        gain_s   = '0;
        addend_s = '0;
        case (state_r)
            ST_MUL_P: begin
                op_s   = {{(SW-W){e_r[W-1]}}, e_r};
                gain_s = kp_r;
            end
            ST_MUL_I: begin
                op_s   = {{(SW-ACC_W){integ_r[ACC_W-1]}}, integ_r};
                gain_s = ki_r;
            end
            ST_MUL_D: begin
                op_s   = {{(SW-W-1){d_r[W]}}, d_r};
                gain_s = kd_r;
            end
            default: begin
                op_s   = '0;
                gain_s = '0;
            end
        endcase
        if (gain_s[bit_cnt_r]) addend_s = op_s <<< bit_cnt_r;
        else                   addend_s = '0;
    end

    // State register, gain-bit counter and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= '0;
            busy      <= 1'b0;
        end else if (ena) begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s != ST_IDLE);
            if ((state_r == ST_MUL_P) || (state_r == ST_MUL_I) || (state_r == ST_MUL_D))
                bit_cnt_r <= last_bit_s ? '0 : bit_cnt_r + CW'(1);
            else
                bit_cnt_r <= '0;
        end
    end

    // Sample capture, integral/derivative update and product accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_r       <= '0;
            kp_r      <= '0;
            ki_r      <= '0;
            kd_r      <= '0;
            e_prior_r <= '0;
            d_r       <= '0;
            integ_r   <= '0;
            sum_r     <= '0;
        end else if (ena) begin
            case (state_r)
                ST_IDLE: begin
                    if (int_clr) begin
                        integ_r   <= '0;
                        e_prior_r <= '0;
                    end
                    if (sample_valid) begin
                        e_r  <= e;
                        kp_r <= K_p;
                        ki_r <= K_i;
                        kd_r <= K_d;
                    end
                end
                ST_LOAD: begin
                    if (!hold_int_s) integ_r <= sat_acc(integ_sum_s);
                    d_r       <= d_s;
                    e_prior_r <= e_r;
                    sum_r     <= '0;
                end
                ST_MUL_P, ST_MUL_I, ST_MUL_D: sum_r <= sum_r + addend_s;
                default: sum_r <= sum_r;
            endcase
        end
    end

    // Output register; u_valid is a single-cycle pulse issued only when SUM executes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u       <= '0;
            u_valid <= 1'b0;
        end else if (ena && (state_r == ST_SUM)) begin
            u       <= sat_w(shifted_s);
            u_valid <= 1'b1;
        end else begin
            u_valid <= 1'b0;
        end
    end
endmodule
